// File: rtl/skip_ctl.sv
//------------------------------------------------------------------------------
// Module   : skip_ctl
// Brief    : Skip-ring sequencer: prescaled tick, ring position, gated slot
//            pulses and wrap-aligned REQ/ACK mask swap.
//            Optional SKIP_CTL_IMM_EN: apply a pending mask at once while E==0.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module skip_ctl #(
    parameter int              LEN      = 16,
    parameter int              DIVW     = 25,
    parameter logic [LEN-1:0]  DEF_MASK = 16'hCCCC,
    localparam int             POSW     = (LEN > 1) ? $clog2(LEN) : 1
) (
    input  logic              iCLK,
    input  logic              RST,
    input  logic              E,
    input  logic [DIVW-1:0]   PRE,
    input  logic              REQ,
    input  logic [LEN-1:0]    nMASK,
    output logic              ACK,
    output logic              oTICK,
    output logic              oSLOT,
    output logic              oB0,
    output logic [POSW-1:0]   oPOS,
    output logic [LEN-1:0]    oMASK
);

    localparam logic [POSW-1:0] c_LAST      = POSW'(LEN - 1);
    localparam logic [0:0]      c_ST_IDLE   = 1'b0;
    localparam logic [0:0]      c_ST_PEND   = 1'b1;

    logic [DIVW-1:0] r_cnt;
    logic [POSW-1:0] r_pos;
    logic [LEN-1:0]  r_amask;
    logic [LEN-1:0]  r_shadow;
    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic            w_tick;
    logic            w_wrap;
    logic            w_capture;
    logic            w_apply;
    logic            w_imm;

    always_comb begin
        w_tick = E && (r_cnt == PRE);
        w_wrap = w_tick && (r_pos == c_LAST);
    end

    // REQ seen in the ACK cycle is ignored so a held REQ cannot re-trigger
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_apply     = 1'b0;
        w_imm       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (REQ && !ACK) begin
                    w_capture   = 1'b1;
                    w_state_nxt = c_ST_PEND;
                end
            end
            c_ST_PEND: begin
                if (w_wrap) begin
                    w_apply = 1'b1;
                end
`ifdef SKIP_CTL_IMM_EN
                else if (!E) begin
                    w_apply = 1'b1;
                    w_imm   = 1'b1;
                end
`endif
                if (w_apply) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge RST) begin
        if (RST) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // No clamping when PRE drops below cnt: the counter wraps naturally
    always_ff @(posedge iCLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
            r_pos <= '0;
        end else if (w_imm) begin
            r_cnt <= '0;
            r_pos <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
            r_pos <= (r_pos == c_LAST) ? '0 : r_pos + POSW'(1);
        end else if (E) begin
            r_cnt <= r_cnt + DIVW'(1);
        end
    end

    always_ff @(posedge iCLK or posedge RST) begin
        if (RST) begin
            r_amask  <= DEF_MASK;
            r_shadow <= '0;
            ACK      <= 1'b0;
        end else begin
            ACK <= w_apply;
            if (w_capture) begin
                r_shadow <= nMASK;
            end
            if (w_apply) begin
                r_amask <= r_shadow;
            end
        end
    end

    always_ff @(posedge iCLK or posedge RST) begin
        if (RST) begin
            oTICK <= 1'b0;
            oSLOT <= 1'b0;
            oB0   <= 1'b0;
        end else begin
            oTICK <= w_tick;
            oSLOT <= w_tick && r_amask[r_pos];
            oB0   <= w_tick && (r_pos == '0);
        end
    end

    assign oPOS  = r_pos;
    assign oMASK = r_amask;

endmodule

`default_nettype wire

// File: tb/tb_skip_ctl.sv
//------------------------------------------------------------------------------
// Module   : tb_skip_ctl
// Brief    : Directed and randomized checks of skip_ctl against a cycle model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_skip_ctl;

    localparam int c_LEN  = 16;
    localparam int c_DIVW = 25;

    logic              iCLK = 1'b0;
    logic              RST;
    logic              E;
    logic [c_DIVW-1:0] PRE;
    logic              REQ;
    logic [c_LEN-1:0]  nMASK;
    logic              ACK;
    logic              oTICK;
    logic              oSLOT;
    logic              oB0;
    logic [3:0]        oPOS;
    logic [c_LEN-1:0]  oMASK;

    skip_ctl #(.LEN(c_LEN), .DIVW(c_DIVW), .DEF_MASK(16'hCCCC)) u_dut (
        .iCLK  (iCLK),
        .RST   (RST),
        .E     (E),
        .PRE   (PRE),
        .REQ   (REQ),
        .nMASK (nMASK),
        .ACK   (ACK),
        .oTICK (oTICK),
        .oSLOT (oSLOT),
        .oB0   (oB0),
        .oPOS  (oPOS),
        .oMASK (oMASK)
    );

    always #5 iCLK = ~iCLK;

    int nerr = 0;
    int nchk = 0;

    // Reference state: what the block should look like after the next edge
    longint      m_cnt;
    int          m_pos;
    logic [15:0] m_mask;
    logic [15:0] m_shadow;
    bit          m_pend;
    bit          e_ack, e_tick, e_slot, e_b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_pos = 0; m_mask = 16'hCCCC; m_shadow = 0; m_pend = 0;
        e_ack = 0; e_tick = 0; e_slot = 0; e_b0 = 0;
    endtask

    task automatic model_step();
        bit     tick;
        bit     ack_n;
        bit     imm;
        tick  = E && (m_cnt == longint'(PRE));
        ack_n = 0;
        imm   = 0;
        e_tick = tick;
        e_slot = tick && m_mask[m_pos];
        e_b0   = tick && (m_pos == 0);
        if (!m_pend) begin
            if (REQ && !e_ack) begin
                m_shadow = nMASK;
                m_pend   = 1;
            end
        end else if (tick && m_pos == c_LEN - 1) begin
            m_mask = m_shadow; ack_n = 1; m_pend = 0;
        end
`ifdef SKIP_CTL_IMM_EN
        else if (!E) begin
            m_mask = m_shadow; ack_n = 1; m_pend = 0; imm = 1;
        end
`endif
        e_ack = ack_n;
        if (tick) begin
            m_cnt = 0;
            m_pos = (m_pos + 1) % c_LEN;
        end else if (E) begin
            m_cnt = (m_cnt + 1) % (longint'(1) << c_DIVW);
        end
        if (imm) begin
            m_cnt = 0;
            m_pos = 0;
        end
    endtask

    task automatic cmp_all();
        chk("ACK",   ACK,   e_ack);
        chk("oTICK", oTICK, e_tick);
        chk("oSLOT", oSLOT, e_slot);
        chk("oB0",   oB0,   e_b0);
        chk("oPOS",  oPOS,  m_pos);
        chk("oMASK", oMASK, m_mask);
    endtask

    task automatic cycle();
        model_step();
        @(posedge iCLK);
        @(negedge iCLK);
        cmp_all();
    endtask

    // Async pulse in the middle of the low phase, released at a later negedge
    task automatic do_reset();
        #2;
        RST = 1'b1;
        REQ = 1'b0;
        #1;
        model_reset();
        cmp_all();
        @(negedge iCLK);
        cmp_all();
        RST = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int n_tick, n_slot, n_b0, n_ack, k, pos0;
        logic [c_DIVW-1:0] newpre;

        RST = 1'b1; E = 1'b0; PRE = 3; REQ = 1'b0; nMASK = '0;
        model_reset();
        repeat (2) @(negedge iCLK);
        cmp_all();
        chk("reset_mask", oMASK, 16'hCCCC);
        RST = 1'b0;
        E   = 1'b1;

        // Plan 1: PRE=3, 64 cycles = one rotation
        n_tick = 0; n_slot = 0; n_b0 = 0;
        for (int i = 0; i < 64; i++) begin
            cycle();
            n_tick += oTICK; n_slot += oSLOT; n_b0 += oB0;
        end
        chk("t1_ticks", n_tick, 16);
        chk("t1_slots", n_slot, 8);
        chk("t1_b0",    n_b0,   1);

        // Plan 2: PRE=0, tick every cycle
        PRE = 0;
        n_tick = 0; n_b0 = 0;
        for (int i = 0; i < 32; i++) begin
            cycle();
            n_tick += oTICK; n_b0 += oB0;
        end
        chk("t2_ticks", n_tick, 32);
        chk("t2_b0",    n_b0,   2);

        // Plan 3: request at pos 5, apply at wrap
        PRE = 1;
        k = 0;
        while (oPOS != 4'd5 && k < 100) begin cycle(); k++; end
        chk("t3_reach_pos5", oPOS, 5);
        REQ = 1'b1; nMASK = 16'h0001;
        k = 0;
        while (!ACK && k < 100) begin cycle(); k++; end
        chk("t3_ack",      ACK,   1);
        chk("t3_ack_tick", oTICK, 1);
        chk("t3_ack_pos",  oPOS,  0);
        chk("t3_ack_mask", oMASK, 16'h0001);
        REQ = 1'b0;
        n_slot = 0; n_b0 = 0;
        for (int i = 0; i < 32; i++) begin
            cycle();
            n_slot += oSLOT; n_b0 += (oSLOT && oB0);
        end
        chk("t3_slots",    n_slot, 1);
        chk("t3_slot0",    n_b0,   1);

        // Plan 4: request lands on the wrap tick itself
        k = 0;
        while (!(m_cnt == longint'(PRE) && m_pos == c_LEN - 1) && k < 100) begin cycle(); k++; end
        REQ = 1'b1; nMASK = 16'hF0F0;
        n_tick = 0; k = 0;
        do begin cycle(); n_tick += oTICK; k++; end while (!ACK && k < 200);
        chk("t4_ack",        ACK,    1);
        chk("t4_ticks",      n_tick, 17);
        chk("t4_mask",       oMASK,  16'hF0F0);
        REQ = 1'b0;
        cycle();

        // Plan 5: request while stalled
        E = 1'b0; REQ = 1'b1; nMASK = 16'h00FF;
        pos0 = m_pos;
        n_ack = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            n_ack += ACK;
            if (ACK) REQ = 1'b0;
        end
`ifdef SKIP_CTL_IMM_EN
        chk("t5_ack_count", n_ack, 1);
        chk("t5_pos",       oPOS,  0);
        chk("t5_mask",      oMASK, 16'h00FF);
`else
        chk("t5_ack_count", n_ack, 0);
        chk("t5_pos",       oPOS,  pos0);
        chk("t5_mask",      oMASK, 16'hF0F0);
`endif

        // Plan 6: reset while pending, mid-prescale
        E = 1'b1; PRE = 3;
        if (!m_pend) begin
            REQ = 1'b1; nMASK = 16'h1234;
            cycle();
        end
        repeat (2) cycle();
        do_reset();
        chk("t6_mask", oMASK, 16'hCCCC);
        chk("t6_pos",  oPOS,  0);
        k = 0;
        while (!oTICK && k < 10) begin cycle(); k++; end
        chk("t6_first_tick", k, 4);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            E = ($urandom % 10) != 0;
            if ($urandom % 50 == 0) begin
                newpre = c_DIVW'($urandom % 4);
                if (longint'(newpre) >= m_cnt) PRE = newpre;
            end
            if (REQ && ACK) begin
                if ($urandom % 2 == 0) REQ = 1'b0;
            end else if (!REQ && ($urandom % 8 == 0)) begin
                REQ = 1'b1; nMASK = 16'($urandom);
            end else if (REQ && ($urandom % 16 == 0)) begin
                nMASK = 16'($urandom);
            end
            if ($urandom % 300 == 0) do_reset();
            else cycle();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

`default_nettype wire
